// File: rtl/rv32i_exec_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_exec_ctrl
//   Main decoder, branch resolver and ALU for the single-cycle RV32I core.
//   Everything is combinational from the instruction fields to the strobes,
//   the ALU result and the PC-select. The only state is the sticky
//   illegal-instruction flag.
//
//   Optional feature macro: RV32I_EXEC_ILLEGAL_TRAP_EN
//     defined   : illegal_instr latches 1 on a clock edge that sees an
//                 unsupported opcode, and holds until reset.
//     undefined : illegal_instr is tied to 0. Unsupported opcodes still
//                 decode as a NOP.
//
//   rst is asynchronous and active-low. While it is low every control output
//   and alu_results is forced to zero, so alu_zero reads 1.
// ---------------------------------------------------------------------------
module rv32i_exec_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic [DATA_WIDTH-1:0] src1,
  input  logic [DATA_WIDTH-1:0] src2,
  input  logic [DATA_WIDTH-1:0] sign_ext,
  output logic                  branch,
  output logic [2:0]            imm_src,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_2_reg,
  output logic                  alu_src,
  output logic [3:0]            alu_ctrl,
  output logic                  reg_write,
  output logic [1:0]            wrt_back_src,
  output logic [DATA_WIDTH-1:0] alu_results,
  output logic                  alu_zero,
  output logic                  illegal_instr
);

  // Opcodes this block supports.
  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_fmt_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wb_src_e;

  // How the PC-select is derived from the ALU zero flag.
  typedef enum logic [1:0] {
    BR_NONE,
    BR_ON_ZERO,
    BR_ON_NONZERO,
    BR_ALWAYS
  } br_kind_e;

  // Map func3 of the register/immediate arithmetic group onto an ALU op.
  // alt selects SUB/SRA. The caller decides when alt is honoured.
  function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  arith_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  imm_fmt_e              dec_imm;
  wb_src_e               dec_wb;
  alu_op_e               dec_alu;
  br_kind_e              dec_br;
  logic                  dec_mem_read;
  logic                  dec_mem_write;
  logic                  dec_mem_2_reg;
  logic                  dec_alu_src;
  logic                  dec_reg_write;
  logic                  supported;

  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_raw;
  logic                  raw_zero;
  logic                  br_taken;
  logic [4:0]            shamt;

  // Main decoder: opcode/func3/func7 to the raw (pre-reset) control set.
  always_comb begin
    // NOTE: every decoder output gets a default before the case, so that no
    // path leaves one unassigned. A missing default would infer a latch.
    dec_imm       = IMM_I;
    dec_wb        = WB_MEM;
    dec_alu       = ALU_ADD;
    dec_br        = BR_NONE;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_mem_2_reg = 1'b0;
    dec_alu_src   = 1'b0;
    dec_reg_write = 1'b0;
    supported     = 1'b1;

    case (opcode)
      OP_R: begin
        dec_alu       = arith_op(func3, func7[5]);
        dec_reg_write = 1'b1;
        dec_wb        = WB_ALU;
      end
      OP_I: begin
        // Only the shift-right slot uses func7. ADDI must ignore it.
        dec_alu       = arith_op(func3, (func3 == 3'b101) && func7[5]);
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_wb        = WB_ALU;
      end
      OP_LOAD: begin
        dec_alu_src   = 1'b1;
        dec_mem_read  = 1'b1;
        dec_mem_2_reg = 1'b1;
        dec_reg_write = 1'b1;
        dec_wb        = WB_MEM;
      end
      OP_STORE: begin
        dec_imm       = IMM_S;
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm = IMM_B;
        // Equality uses SUB. The ordered compares use SLT/SLTU, where a
        // nonzero result means "less than".
        case (func3)
          3'b000:  begin dec_alu = ALU_SUB;  dec_br = BR_ON_ZERO;    end
          3'b001:  begin dec_alu = ALU_SUB;  dec_br = BR_ON_NONZERO; end
          3'b100:  begin dec_alu = ALU_SLT;  dec_br = BR_ON_NONZERO; end
          3'b101:  begin dec_alu = ALU_SLT;  dec_br = BR_ON_ZERO;    end
          3'b110:  begin dec_alu = ALU_SLTU; dec_br = BR_ON_NONZERO; end
          3'b111:  begin dec_alu = ALU_SLTU; dec_br = BR_ON_ZERO;    end
          default: begin dec_alu = ALU_ADD;  dec_br = BR_NONE;       end
        endcase
      end
      OP_JAL: begin
        dec_imm       = IMM_J;
        dec_br        = BR_ALWAYS;
        dec_reg_write = 1'b1;
        dec_wb        = WB_PC4;
      end
      OP_JALR: begin
        dec_alu_src   = 1'b1;
        dec_br        = BR_ALWAYS;
        dec_reg_write = 1'b1;
        dec_wb        = WB_PC4;
      end
      OP_LUI: begin
        dec_imm       = IMM_U;
        dec_alu       = ALU_PASSB;
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
        dec_wb        = WB_ALU;
      end
      default: begin
        // AUIPC and everything else: NOP with ALU on ADD.
        supported = 1'b0;
      end
    endcase
  end

  assign op_b  = dec_alu_src ? sign_ext : src2;
  assign shamt = op_b[4:0];

  // ALU: add/sub wrap silently, shifts use the low five bits of operand B.
  always_comb begin
    alu_raw = '0;
    case (dec_alu)
      ALU_ADD:   alu_raw = src1 + op_b;
      ALU_SUB:   alu_raw = src1 - op_b;
      ALU_AND:   alu_raw = src1 & op_b;
      ALU_OR:    alu_raw = src1 | op_b;
      ALU_XOR:   alu_raw = src1 ^ op_b;
      ALU_SLL:   alu_raw = src1 << shamt;
      ALU_SRL:   alu_raw = src1 >> shamt;
      ALU_SRA:   alu_raw = $signed(src1) >>> shamt;
      ALU_SLT:   alu_raw = {{(DATA_WIDTH-1){1'b0}}, $signed(src1) < $signed(op_b)};
      ALU_SLTU:  alu_raw = {{(DATA_WIDTH-1){1'b0}}, src1 < op_b};
      ALU_PASSB: alu_raw = op_b;
      default:   alu_raw = '0;
    endcase
  end

  assign raw_zero = (alu_raw == '0);

  // Branch resolver: combine the decoded branch kind with the ALU zero flag.
  always_comb begin
    br_taken = 1'b0;
    case (dec_br)
      BR_ON_ZERO:    br_taken = raw_zero;
      BR_ON_NONZERO: br_taken = !raw_zero;
      BR_ALWAYS:     br_taken = 1'b1;
      default:       br_taken = 1'b0;
    endcase
  end

  // Output stage: while reset is asserted, force every strobe and the result
  // to zero without waiting for a clock.
  always_comb begin
    branch       = 1'b0;
    imm_src      = IMM_I;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_2_reg    = 1'b0;
    alu_src      = 1'b0;
    alu_ctrl     = ALU_ADD;
    reg_write    = 1'b0;
    wrt_back_src = WB_MEM;
    alu_results  = '0;
    if (rst) begin
      branch       = br_taken;
      imm_src      = dec_imm;
      mem_read     = dec_mem_read;
      mem_write    = dec_mem_write;
      mem_2_reg    = dec_mem_2_reg;
      alu_src      = dec_alu_src;
      alu_ctrl     = dec_alu;
      reg_write    = dec_reg_write;
      wrt_back_src = dec_wb;
      alu_results  = alu_raw;
    end
  end

  assign alu_zero = (alu_results == '0);

`ifdef RV32I_EXEC_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky trap flag: set by any clocked unsupported opcode, cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state updates with non-blocking assignments, so every flop samples
    // the pre-edge values regardless of block evaluation order.
    if (!rst) begin
      illegal_q <= 1'b0;
    end else if (!supported) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_instr = illegal_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, func7[6], func7[4:0]};
`else
  assign illegal_instr = 1'b0;

  // Without the trap, the clock and the opcode-support flag have no reader.
  logic unused_bits;
  assign unused_bits = &{1'b0, clk, supported, func7[6], func7[4:0]};
`endif

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv32i_exec_ctrl
//   Directed vectors for rv32i_exec_ctrl. A per-instruction semantic model
//   (what each RV32I instruction should compute and strobe) is checked
//   against the DUT on every falling edge. Hand-computed literals pin the
//   model for the interesting cases.
// ---------------------------------------------------------------------------
module tb_rv32i_exec_ctrl;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] src1, src2, sign_ext;

  logic        branch, mem_read, mem_write, mem_2_reg, alu_src, reg_write;
  logic        alu_zero, illegal_instr;
  logic [2:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wrt_back_src;
  logic [31:0] alu_results;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit m_ill;

  always #5 clk = ~clk;

  rv32i_exec_ctrl #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .func3        (func3),
    .func7        (func7),
    .src1         (src1),
    .src2         (src2),
    .sign_ext     (sign_ext),
    .branch       (branch),
    .imm_src      (imm_src),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_2_reg    (mem_2_reg),
    .alu_src      (alu_src),
    .alu_ctrl     (alu_ctrl),
    .reg_write    (reg_write),
    .wrt_back_src (wrt_back_src),
    .alu_results  (alu_results),
    .alu_zero     (alu_zero),
    .illegal_instr(illegal_instr)
  );

  typedef struct packed {
    logic        branch;
    logic [2:0]  imm_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_2_reg;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic        reg_write;
    logic [1:0]  wb;
    logic [31:0] res;
  } exp_t;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_supported(input logic [6:0] op);
    return op inside {OPC_R, OPC_I, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                      OPC_JAL, OPC_JALR, OPC_LUI};
  endfunction

  // Instruction semantics: what the datapath must produce for one instruction.
  function automatic exp_t model(input logic r, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] imm);
    exp_t        e;
    logic [31:0] y;
    logic        lt_s, lt_u;
    e = '0;
    if (!r) return e;
    e.res = a + b;
    case (op)
      OPC_R, OPC_I: begin
        y           = (op == OPC_I) ? imm : b;
        e.alu_src   = (op == OPC_I);
        e.reg_write = 1'b1;
        e.wb        = 2'b01;
        case (f3)
          3'd0: if (op == OPC_R && f7[5]) begin e.alu_ctrl = 4'b0001; e.res = a - y; end
                else begin e.alu_ctrl = 4'b0000; e.res = a + y; end
          3'd1: begin e.alu_ctrl = 4'b0101; e.res = a << y[4:0]; end
          3'd2: begin e.alu_ctrl = 4'b1000; e.res = {31'b0, $signed(a) < $signed(y)}; end
          3'd3: begin e.alu_ctrl = 4'b1001; e.res = {31'b0, a < y}; end
          3'd4: begin e.alu_ctrl = 4'b0100; e.res = a ^ y; end
          3'd5: if (f7[5]) begin e.alu_ctrl = 4'b0111; e.res = $signed(a) >>> y[4:0]; end
                else begin e.alu_ctrl = 4'b0110; e.res = a >> y[4:0]; end
          3'd6: begin e.alu_ctrl = 4'b0011; e.res = a | y; end
          default: begin e.alu_ctrl = 4'b0010; e.res = a & y; end
        endcase
      end
      OPC_LOAD: begin
        e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_2_reg = 1'b1;
        e.reg_write = 1'b1; e.wb = 2'b00; e.res = a + imm;
      end
      OPC_STORE: begin
        e.imm_src = 3'b001; e.alu_src = 1'b1; e.mem_write = 1'b1; e.res = a + imm;
      end
      OPC_BRANCH: begin
        e.imm_src = 3'b010;
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        case (f3)
          3'd0: begin e.alu_ctrl = 4'b0001; e.res = a - b; e.branch = (a == b); end
          3'd1: begin e.alu_ctrl = 4'b0001; e.res = a - b; e.branch = (a != b); end
          3'd4: begin e.alu_ctrl = 4'b1000; e.res = {31'b0, lt_s}; e.branch = lt_s;  end
          3'd5: begin e.alu_ctrl = 4'b1000; e.res = {31'b0, lt_s}; e.branch = !lt_s; end
          3'd6: begin e.alu_ctrl = 4'b1001; e.res = {31'b0, lt_u}; e.branch = lt_u;  end
          3'd7: begin e.alu_ctrl = 4'b1001; e.res = {31'b0, lt_u}; e.branch = !lt_u; end
          default: e.branch = 1'b0;
        endcase
      end
      OPC_JAL: begin
        e.imm_src = 3'b100; e.branch = 1'b1; e.reg_write = 1'b1; e.wb = 2'b10;
      end
      OPC_JALR: begin
        e.alu_src = 1'b1; e.branch = 1'b1; e.reg_write = 1'b1; e.wb = 2'b10;
        e.res = a + imm;
      end
      OPC_LUI: begin
        e.imm_src = 3'b011; e.alu_ctrl = 4'b1010; e.alu_src = 1'b1;
        e.reg_write = 1'b1; e.wb = 2'b01; e.res = imm;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Reference for the sticky trap flag.
`ifdef RV32I_EXEC_ILLEGAL_TRAP_EN
  always @(posedge clk or negedge rst) begin
    if (!rst) m_ill <= 1'b0;
    else if (!is_supported(opcode)) m_ill <= 1'b1;
  end
`else
  initial m_ill = 1'b0;
`endif

  // Compare process: full output set against the model on every falling edge.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (cmp_en) begin
      e = model(rst, opcode, func3, func7, src1, src2, sign_ext);
      check("branch",       {31'b0, branch},       {31'b0, e.branch});
      check("imm_src",      {29'b0, imm_src},      {29'b0, e.imm_src});
      check("mem_read",     {31'b0, mem_read},     {31'b0, e.mem_read});
      check("mem_write",    {31'b0, mem_write},    {31'b0, e.mem_write});
      check("mem_2_reg",    {31'b0, mem_2_reg},    {31'b0, e.mem_2_reg});
      check("alu_src",      {31'b0, alu_src},      {31'b0, e.alu_src});
      check("alu_ctrl",     {28'b0, alu_ctrl},     {28'b0, e.alu_ctrl});
      check("reg_write",    {31'b0, reg_write},    {31'b0, e.reg_write});
      check("wrt_back_src", {30'b0, wrt_back_src}, {30'b0, e.wb});
      check("alu_results",  alu_results,           e.res);
      check("alu_zero",     {31'b0, alu_zero},     {31'b0, (e.res == 32'h0)});
      check("illegal_instr",{31'b0, illegal_instr},{31'b0, m_ill});
    end
  end

  // Drive one instruction just after a rising edge, then wait until it has
  // been compared on the falling edge.
  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    @(posedge clk);
    #1;
    opcode = op; func3 = f3; func7 = f7; src1 = a; src2 = b; sign_ext = imm;
    @(negedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b0;
    opcode = OPC_LOAD; func3 = 3'd2; func7 = 7'd0;
    src1 = 32'h10; src2 = 32'h20; sign_ext = 32'h4;
    cmp_en = 1'b1;

    // Reset state: LOAD on the inputs, but everything forced low.
    #2;
    check("rst mem_read",     {31'b0, mem_read},    32'd0);
    check("rst reg_write",    {31'b0, reg_write},   32'd0);
    check("rst alu_results",  alu_results,          32'h0);
    check("rst alu_zero",     {31'b0, alu_zero},    32'd1);
    check("rst illegal",      {31'b0, illegal_instr}, 32'd0);
    #10 rst = 1'b1;

    // Model-checked sweep over every supported instruction shape.
    vecs.push_back('{OPC_R, 3'd0, 7'd0,   32'h7FFFFFFF, 32'h1,        32'h0});
    vecs.push_back('{OPC_R, 3'd0, F7_ALT, 32'h0,        32'h1,        32'h0});
    vecs.push_back('{OPC_R, 3'd1, 7'd0,   32'h1,        32'h2F,       32'h0});
    vecs.push_back('{OPC_R, 3'd4, 7'd0,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h0});
    vecs.push_back('{OPC_R, 3'd5, 7'd0,   32'h80000000, 32'h24,       32'h0});
    vecs.push_back('{OPC_R, 3'd6, 7'd0,   32'h00FF0000, 32'h000000FF, 32'h0});
    vecs.push_back('{OPC_R, 3'd7, 7'd0,   32'hFF00FF00, 32'h0F0F0F0F, 32'h0});
    vecs.push_back('{OPC_I, 3'd0, F7_ALT, 32'h10,       32'hDEAD,     32'hFFFFFFFF});
    vecs.push_back('{OPC_I, 3'd5, F7_ALT, 32'h80000010, 32'h0,        32'h3});
    vecs.push_back('{OPC_I, 3'd5, 7'd0,   32'h80000010, 32'h0,        32'h3});
    vecs.push_back('{OPC_I, 3'd2, 7'd0,   32'hFFFFFFF0, 32'h0,        32'h5});
    vecs.push_back('{OPC_I, 3'd3, 7'd0,   32'h5,        32'h0,        32'hFFFFFFFF});
    vecs.push_back('{OPC_I, 3'd7, 7'd0,   32'h12345678, 32'h0,        32'h0000FFFF});
    vecs.push_back('{OPC_BRANCH, 3'd4, 7'd0, 32'hFFFFFFFF, 32'h1,      32'h8});
    vecs.push_back('{OPC_BRANCH, 3'd4, 7'd0, 32'h1,        32'hFFFFFFFF, 32'h8});
    vecs.push_back('{OPC_BRANCH, 3'd5, 7'd0, 32'hFFFFFFFF, 32'h1,      32'h8});
    vecs.push_back('{OPC_BRANCH, 3'd5, 7'd0, 32'h7,        32'h7,      32'h8});
    vecs.push_back('{OPC_BRANCH, 3'd6, 7'd0, 32'h1,        32'hFFFFFFFF, 32'h8});
    vecs.push_back('{OPC_BRANCH, 3'd6, 7'd0, 32'hFFFFFFFF, 32'h1,      32'h8});
    vecs.push_back('{OPC_BRANCH, 3'd7, 7'd0, 32'hFFFFFFFF, 32'h1,      32'h8});
    vecs.push_back('{OPC_BRANCH, 3'd7, 7'd0, 32'h1,        32'h2,      32'h8});
    vecs.push_back('{OPC_BRANCH, 3'd2, 7'd0, 32'h4,        32'h4,      32'h8});
    vecs.push_back('{OPC_BRANCH, 3'd0, 7'd0, 32'h4,        32'h9,      32'h8});
    vecs.push_back('{OPC_JALR,   3'd0, 7'd0, 32'h1000,     32'h55,     32'hFFFFFFFC});
    vecs.push_back('{OPC_LOAD,   3'd2, 7'd0, 32'hFFFFFFFF, 32'h9,      32'h1});
    foreach (vecs[i]) apply(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].imm);

    // Hand-computed cases.
    apply(OPC_BRANCH, 3'd1, 7'd0, 32'h1, 32'h3, 32'h10);
    check("bne alu_ctrl", {28'b0, alu_ctrl}, 32'h1);
    check("bne result",   alu_results, 32'hFFFFFFFE);
    check("bne zero",     {31'b0, alu_zero}, 32'd0);
    check("bne branch",   {31'b0, branch}, 32'd1);
    check("bne reg_write",{31'b0, reg_write}, 32'd0);
    check("bne imm_src",  {29'b0, imm_src}, 32'h2);
    apply(OPC_BRANCH, 3'd1, 7'd0, 32'h5, 32'h5, 32'h10);
    check("bne eq zero",  {31'b0, alu_zero}, 32'd1);
    check("bne eq branch",{31'b0, branch}, 32'd0);
    apply(OPC_BRANCH, 3'd0, 7'd0, 32'h5, 32'h5, 32'h10);
    check("beq branch",   {31'b0, branch}, 32'd1);
    apply(OPC_LOAD, 3'd2, 7'd0, 32'h0, 32'h77, 32'hC);
    check("lw result",    alu_results, 32'h0000000C);
    check("lw mem_read",  {31'b0, mem_read}, 32'd1);
    check("lw mem_2_reg", {31'b0, mem_2_reg}, 32'd1);
    check("lw wb",        {30'b0, wrt_back_src}, 32'd0);
    check("lw reg_write", {31'b0, reg_write}, 32'd1);
    apply(OPC_STORE, 3'd2, 7'd0, 32'h0, 32'h77, 32'hC);
    check("sw mem_write", {31'b0, mem_write}, 32'd1);
    check("sw reg_write", {31'b0, reg_write}, 32'd0);
    check("sw imm_src",   {29'b0, imm_src}, 32'h1);
    apply(OPC_R, 3'd0, F7_ALT, 32'h3, 32'h5, 32'h0);
    check("sub result",   alu_results, 32'hFFFFFFFE);
    apply(OPC_R, 3'd5, F7_ALT, 32'h80000000, 32'h4, 32'h0);
    check("sra result",   alu_results, 32'hF8000000);
    apply(OPC_R, 3'd2, 7'd0, 32'hFFFFFFFF, 32'h1, 32'h0);
    check("slt result",   alu_results, 32'h1);
    apply(OPC_R, 3'd3, 7'd0, 32'hFFFFFFFF, 32'h1, 32'h0);
    check("sltu result",  alu_results, 32'h0);
    apply(OPC_JAL, 3'd0, 7'd0, 32'h20, 32'h30, 32'h800);
    check("jal branch",   {31'b0, branch}, 32'd1);
    check("jal wb",       {30'b0, wrt_back_src}, 32'h2);
    check("jal reg_write",{31'b0, reg_write}, 32'd1);
    apply(OPC_LUI, 3'd0, 7'd0, 32'hAAAA5555, 32'h0, 32'h12345000);
    check("lui result",   alu_results, 32'h12345000);

    // Unsupported opcodes decode as NOP. The flag only moves on a clock edge.
    apply(OPC_AUIPC, 3'd0, 7'd0, 32'h1, 32'h2, 32'h3000);
    check("auipc reg_write", {31'b0, reg_write}, 32'd0);
    check("auipc branch",    {31'b0, branch}, 32'd0);
    check("auipc alu_ctrl",  {28'b0, alu_ctrl}, 32'h0);
    check("auipc illegal pre-edge", {31'b0, illegal_instr}, 32'd0);
    apply(OPC_R, 3'd0, 7'd0, 32'h1, 32'h2, 32'h0);
`ifdef RV32I_EXEC_ILLEGAL_TRAP_EN
    check("illegal set",     {31'b0, illegal_instr}, 32'd1);
`else
    check("illegal tied",    {31'b0, illegal_instr}, 32'd0);
`endif
    apply(7'b1111111, 3'd0, 7'd0, 32'h0, 32'h0, 32'h0);
    apply(OPC_R, 3'd6, 7'd0, 32'h1, 32'h2, 32'h0);
    apply(OPC_I, 3'd0, 7'd0, 32'h1, 32'h0, 32'h1);
`ifdef RV32I_EXEC_ILLEGAL_TRAP_EN
    check("illegal held",    {31'b0, illegal_instr}, 32'd1);
`else
    check("illegal still 0", {31'b0, illegal_instr}, 32'd0);
`endif

    // Reset pulled mid-instruction: strobes drop with no clock edge.
    apply(OPC_LOAD, 3'd2, 7'd0, 32'h100, 32'h0, 32'h8);
    #2 rst = 1'b0;
    #1;
    check("mid rst mem_read",  {31'b0, mem_read}, 32'd0);
    check("mid rst mem_2_reg", {31'b0, mem_2_reg}, 32'd0);
    check("mid rst reg_write", {31'b0, reg_write}, 32'd0);
    check("mid rst alu_src",   {31'b0, alu_src}, 32'd0);
    check("mid rst result",    alu_results, 32'h0);
    check("mid rst illegal",   {31'b0, illegal_instr}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    apply(OPC_R, 3'd0, 7'd0, 32'h2, 32'h3, 32'h0);
    check("post rst result",   alu_results, 32'h5);
    check("post rst illegal",  {31'b0, illegal_instr}, 32'd0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_ctrl.md
Name: rv32i_exec_ctrl

Overview:
- Combined main decoder, branch resolver and ALU for the single-cycle RV32I core.
- Takes opcode/func3/func7 fields, register operands and the sign-extended immediate.
- Produces all datapath control strobes, the ALU result and the PC-select (branch) signal.
- Sits between the register file / sign extender and the data BRAM / write-back mux.

Parameters:
- DATA_WIDTH, 32, operand/result width.

Ports:
- clk  in  1  system clock; used only by the sticky status flag.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction[6:0].
- func3  in  3  instruction[14:12].
- func7  in  7  instruction[31:25].
- src1  in  DATA_WIDTH  rs1 value.
- src2  in  DATA_WIDTH  rs2 value.
- sign_ext  in  DATA_WIDTH  sign-extended immediate.
- branch  out  1  PC select; 1 = take PC+immediate.
- imm_src  out  3  immediate format: I=000, S=001, B=010, U=011, J=100.
- mem_read  out  1  data BRAM read enable.
- mem_write  out  1  data BRAM write enable.
- mem_2_reg  out  1  load in progress.
- alu_src  out  1  0 = src2, 1 = sign_ext as ALU operand B.
- alu_ctrl  out  4  decoded ALU operation.
- reg_write  out  1  register file write enable.
- wrt_back_src  out  2  write-back select: MEMORY_READ=00, ALU_RESULTS=01, PC_PLUS_4=10.
- alu_results  out  DATA_WIDTH  ALU output.
- alu_zero  out  1  alu_results == 0.
- illegal_instr  out  1  sticky unsupported-opcode flag.

Behaviour:
- Fully combinational apart from illegal_instr; zero-cycle latency from fields to all strobes.
- rst==0: all control outputs and alu_results forced to 0 (combinational override); illegal_instr cleared asynchronously.
- ALU operand B = alu_src ? sign_ext : src2.
- alu_ctrl encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000 (signed), SLTU 1001, PASSB 1010.
- Shifts use B[4:0]. Add/sub wrap modulo 2^32 with no overflow flag. Unused alu_ctrl codes give result 0.
- R-type (0110011): alu_src=0, reg_write=1, wb=01. func3/func7[5] select the op; SUB/SRA when func7[5]=1.
- I-ALU (0010011): imm_src I, alu_src=1, reg_write=1, wb=01. SRAI when func7[5]=1; ADDI ignores func7.
- LOAD (0000011): ADD, imm I, alu_src=1, mem_read=1, mem_2_reg=1, reg_write=1, wb=00.
- STORE (0100011): ADD, imm S, alu_src=1, mem_write=1, reg_write=0.
- BRANCH (1100011): imm B, alu_src=0, no writes.
  - BEQ: SUB, branch=zero.
  - BNE: SUB, branch=!zero.
  - BLT: SLT, branch=!zero.
  - BGE: SLT, branch=zero.
  - BLTU: SLTU, branch=!zero.
  - BGEU: SLTU, branch=zero.
  - func3 010/011: branch=0.
- JAL (1101111): imm J, branch=1, reg_write=1, wb=10.
- JALR (1100111): imm I, ADD, alu_src=1, branch=1, reg_write=1, wb=10.
- LUI (0110111): imm U, PASSB, alu_src=1, reg_write=1, wb=01.
- Any other opcode, including AUIPC: all strobes 0 (NOP), alu_ctrl ADD.
- branch is 0 for every non-branch/non-jump opcode.

Optional Feature:
- Macro: RV32I_EXEC_ILLEGAL_TRAP_EN.
- Defined: on a rising clk with rst=1 and an unsupported opcode, illegal_instr sets and stays 1 until reset.
- Undefined: illegal_instr tied 0; unsupported opcodes still decode as NOP.

Test Plan:
- BNE, src1=1, src2=3 -> alu_ctrl=0001, alu_results=FFFFFFFE, zero=0, branch=1, reg_write=0, imm_src=010.
- BNE, src1=5, src2=5 -> zero=1, branch=0. Same operands with BEQ -> branch=1.
- LOAD, src1=0, sign_ext=C -> alu_results=0000000C, mem_read=1, mem_2_reg=1, wb=00, reg_write=1. STORE with same operands -> mem_write=1, reg_write=0, imm_src=001.
- R SUB, src1=3, src2=5 -> FFFFFFFE. SRA with src1=80000000, shift 4 -> F8000000. SLT with -1 vs 1 -> 1; SLTU with same operands -> 0.
- JAL -> branch=1, wb=10, reg_write=1. LUI, sign_ext=12345000 -> alu_results=12345000.
- rst=0 mid-instruction -> all strobes 0 immediately. With the macro defined, opcode 0010111 clocked -> illegal_instr=1, held until rst=0.
